// File: rtl/dual_config_pkg.sv
// dual_config_pkg: register map and FSM state type for the MAX10 dual-config receive port.
// The WR_WDT state exists only when DUAL_CONFIG_WDT_EN is defined.
package dual_config_pkg;
    localparam logic [2:0] ADDR_TRIG = 3'd0;
    localparam logic [2:0] ADDR_SEL  = 3'd1;
    localparam logic [2:0] ADDR_BUSY = 3'd2;
    localparam int BIT_TRIG    = 0;
    localparam int BIT_WDT     = 1;
    localparam int BIT_SEL_OVR = 0;
    localparam int BIT_SEL     = 1;
    localparam int BIT_BUSY    = 0;
    localparam logic [31:0] WD_TRIG = 32'(1) << BIT_TRIG;
    localparam logic [31:0] WD_WDT  = 32'(1) << BIT_WDT;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_WR_SEL,
        ST_WR_TRIG,
        ST_TRIGGERED,
        ST_ERROR
`ifdef DUAL_CONFIG_WDT_EN
        , ST_WR_WDT
`endif
    } dual_config_ctrl_state_t;
    function automatic logic [31:0] sel_word(input logic img);
        return (32'(img) << BIT_SEL) | (32'(1) << BIT_SEL_OVR);
    endfunction
endpackage

// File: rtl/dual_config_ctrl.sv
// dual_config_ctrl: Avalon-MM master that polls busy, selects the boot image and triggers reconfiguration.
// Define DUAL_CONFIG_WDT_EN to enable watchdog-kick servicing.
module dual_config_ctrl
    import dual_config_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int POLL_TIMEOUT = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_image,
    output logic        req_ready,
    input  logic        wdt_kick,
    output logic [2:0]  avmm_rcv_address,
    output logic        avmm_rcv_read,
    output logic        avmm_rcv_write,
    output logic [31:0] avmm_rcv_writedata,
    input  logic [31:0] avmm_rcv_readdata,
    output logic        ctrl_busy,
    output logic        ctrl_done,
    output logic        ctrl_error
);
    localparam int TW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(POLL_TIMEOUT);
    localparam logic [2:0] RL = 3'(READ_LATENCY);
    dual_config_ctrl_state_t state;
    logic          image;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    lat_cnt;
`ifdef DUAL_CONFIG_WDT_EN
    logic kick_pending;
    logic unused_bits;
    assign unused_bits = ^avmm_rcv_readdata[31:1];
    assign req_ready = (state == ST_IDLE) & ~kick_pending;
`else
    logic unused_bits;
    assign unused_bits = ^{avmm_rcv_readdata[31:1], wdt_kick};
    assign req_ready = (state == ST_IDLE);
`endif
    assign ctrl_busy = (state != ST_IDLE);
    // Avalon outputs are set on the transition into the strobing state, so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            image              <= 1'b0;
            tmo_cnt            <= '0;
            lat_cnt            <= '0;
            avmm_rcv_address   <= '0;
            avmm_rcv_read      <= 1'b0;
            avmm_rcv_write     <= 1'b0;
            avmm_rcv_writedata <= '0;
            ctrl_done          <= 1'b0;
            ctrl_error         <= 1'b0;
`ifdef DUAL_CONFIG_WDT_EN
            kick_pending       <= 1'b0;
`endif
        end else begin
            avmm_rcv_address   <= '0;
            avmm_rcv_read      <= 1'b0;
            avmm_rcv_write     <= 1'b0;
            avmm_rcv_writedata <= '0;
            if (state == ST_POLL_RD || state == ST_POLL_WAIT)
                tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
`ifdef DUAL_CONFIG_WDT_EN
            kick_pending <= (wdt_kick && state != ST_TRIGGERED) || (kick_pending && state != ST_WR_WDT);
`endif
            case (state)
                ST_IDLE:
`ifdef DUAL_CONFIG_WDT_EN
                    if (kick_pending) begin
                        state              <= ST_WR_WDT;
                        avmm_rcv_write     <= 1'b1;
                        avmm_rcv_address   <= ADDR_TRIG;
                        avmm_rcv_writedata <= WD_WDT;
                    end else
`endif
                    if (req_valid) begin
                        state            <= ST_POLL_RD;
                        avmm_rcv_read    <= 1'b1;
                        avmm_rcv_address <= ADDR_BUSY;
                        ctrl_error       <= 1'b0;
                        image            <= req_image;
                        tmo_cnt          <= '0;
                    end
                ST_POLL_RD: begin
                    state   <= ST_POLL_WAIT;
                    lat_cnt <= 3'd1;
                end
                ST_POLL_WAIT:
                    if (lat_cnt != RL) lat_cnt <= lat_cnt + 3'd1;
                    else if (!avmm_rcv_readdata[BIT_BUSY]) begin
                        state              <= ST_WR_SEL;
                        avmm_rcv_write     <= 1'b1;
                        avmm_rcv_address   <= ADDR_SEL;
                        avmm_rcv_writedata <= sel_word(image);
                    end else if (tmo_cnt < TMO) begin
                        state            <= ST_POLL_RD;
                        avmm_rcv_read    <= 1'b1;
                        avmm_rcv_address <= ADDR_BUSY;
                    end else state <= ST_ERROR;
                ST_WR_SEL: begin
                    state              <= ST_WR_TRIG;
                    avmm_rcv_write     <= 1'b1;
                    avmm_rcv_address   <= ADDR_TRIG;
                    avmm_rcv_writedata <= WD_TRIG;
                end
                ST_WR_TRIG: begin
                    state     <= ST_TRIGGERED;
                    ctrl_done <= 1'b1;
                end
                ST_TRIGGERED: state <= ST_TRIGGERED;
                ST_ERROR: begin
                    state      <= ST_IDLE;
                    ctrl_error <= 1'b1;
                end
`ifdef DUAL_CONFIG_WDT_EN
                ST_WR_WDT: state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
